// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio
// Purpose  : Data-port responder for the single-cycle ARM core. Decodes the
//            byte address into a word RAM (DataAdr[12]=0) and an I/O page
//            (DataAdr[12]=1) holding LEDs, synchronized switches, a
//            free-running timer and a byte TX FIFO with valid/ready output.
// Revision : 1.0  initial release
// ============================================================================
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int LED_W      = 8,
  parameter int SW_W       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_SW     = 3'd1;
  localparam logic [2:0] OFF_TIMER  = 3'd2;
  localparam logic [2:0] OFF_TXDATA = 3'd3;
  localparam logic [2:0] OFF_TXSTAT = 3'd4;

  // Storage arrays (never reset)
  logic [31:0] ram_q      [RAM_WORDS];
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];

  // Registered state
  logic [LED_W-1:0] led_q,      led_d;
  logic [SW_W-1:0]  sw_meta_q,  sw_meta_d;
  logic [SW_W-1:0]  sw_sync_q,  sw_sync_d;
  logic [31:0]      timer_q,    timer_d;
  logic [PW-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]    count_q,    count_d;
  logic             overflow_q, overflow_d;

  // Decode
  logic              io_sel;
  logic [2:0]        io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_ram;
  logic              wr_io;
  logic              wr_led;
  logic              wr_timer;
  logic              push_req;
  logic              clr_ovf;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [31:0]       txstat;

  // Address bits that only alias; collected so they are visibly consumed
  logic unused_bits;
  assign unused_bits = ^{DataAdr[31:13], DataAdr[11:5], DataAdr[1:0], WriteData};

  assign io_sel   = DataAdr[12];
  assign io_off   = DataAdr[4:2];
  assign ram_idx  = DataAdr[RAM_AW+1:2];
  assign wr_ram   = MemWrite & ~io_sel;
  assign wr_io    = MemWrite & io_sel;
  assign wr_led   = wr_io & (io_off == OFF_LED);
  assign wr_timer = wr_io & (io_off == OFF_TIMER);
  assign push_req = wr_io & (io_off == OFF_TXDATA);
  assign clr_ovf  = wr_io & (io_off == OFF_TXSTAT) & WriteData[2];

  // FIFO handshake: a pop frees a slot for a same-cycle push when full
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == C_DEPTH);
  assign pop        = ~fifo_empty & tx_ready;
  assign push       = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;

  assign txstat = {16'h0000, 8'(count_q), 5'b00000, overflow_q, fifo_full, fifo_empty};

  assign led      = led_q;
  assign tx_data  = fifo_mem_q[rd_ptr_q];
  assign tx_valid = ~fifo_empty;

  // Combinational load data; reads never alter state
  always_comb begin
    ReadData = 32'h0;
    if (!io_sel) begin
      ReadData = ram_q[ram_idx];
    end else begin
      case (io_off)
        OFF_LED:    ReadData = 32'(led_q);
        OFF_SW:     ReadData = 32'(sw_sync_q);
        OFF_TIMER:  ReadData = timer_q;
        OFF_TXSTAT: ReadData = txstat;
        default:    ReadData = 32'h0;
      endcase
    end
  end

  // Next-state computation for registers, timer and FIFO bookkeeping
  always_comb begin
    led_d      = led_q;
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    timer_d    = timer_q + 32'd1;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_led) begin
      led_d = WriteData[LED_W-1:0];
    end
    if (wr_timer) begin
      timer_d = WriteData;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A dropped push sets overflow even when a clear arrives together
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      timer_q    <= 32'h0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      timer_q    <= timer_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM store port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram_q[ram_idx] <= WriteData;
    end
  end

  // FIFO storage write; a push in a reset cycle is discarded
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem_q[wr_ptr_q] <= WriteData[7:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio
// Purpose  : Directed and randomized bench for dmem_mmio against a queue and
//            array based reference model of the memory map.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_mmio;

  localparam int RAM_WORDS  = 64;
  localparam int LED_W      = 8;
  localparam int SW_W       = 8;
  localparam int FIFO_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             MemWrite;
  logic [31:0]      DataAdr;
  logic [31:0]      WriteData;
  logic [31:0]      ReadData;
  logic [SW_W-1:0]  sw;
  logic [LED_W-1:0] led;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  always #5 clk = ~clk;

  dmem_mmio #(
    .RAM_WORDS (RAM_WORDS),
    .LED_W     (LED_W),
    .SW_W      (SW_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .sw       (sw),
    .led      (led),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]      m_ram   [RAM_WORDS];
  bit               m_known [RAM_WORDS];
  logic [LED_W-1:0] m_led;
  logic [SW_W-1:0]  m_s1;
  logic [SW_W-1:0]  m_s2;
  logic [31:0]      m_timer;
  logic [7:0]       m_q [$];
  bit               m_ovf;
  bit               m_valid = 1'b0;
  logic [SW_W-1:0]  sw_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2) % RAM_WORDS;
    if (!a[12]) return m_ram[idx];
    case (a[4:2])
      3'd0: return 32'(m_led);
      3'd1: return 32'(m_s2);
      3'd2: return m_timer;
      3'd4: return {16'h0, 8'(m_q.size()), 5'h0, m_ovf,
                    (m_q.size() == FIFO_DEPTH), (m_q.size() == 0)};
      default: return 32'h0;
    endcase
  endfunction

  // Apply inputs for one cycle, then compare outputs with the model
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input logic rst);
    int idx;
    MemWrite  = we;
    DataAdr   = a;
    WriteData = wd;
    tx_ready  = rdy;
    sw        = sw_val;
    reset     = rst;
    #1;
    if (m_valid) begin
      idx = int'(a >> 2) % RAM_WORDS;
      if (a[12] || m_known[idx]) chk("rdata", ReadData, m_read(a));
      chk("led", 32'(led), 32'(m_led));
      chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
    end
  endtask

  // Advance one clock edge and apply the memory-map rules to the model
  task automatic tick();
    int  idx;
    bit  pop;
    @(posedge clk);
    idx = int'(DataAdr >> 2) % RAM_WORDS;
    if (reset) begin
      m_led   = '0;
      m_s1    = '0;
      m_s2    = '0;
      m_timer = 32'h0;
      m_q.delete();
      m_ovf   = 1'b0;
      m_valid = 1'b1;
      if (MemWrite && !DataAdr[12]) m_known[idx] = 1'b0;
    end else begin
      pop     = (m_q.size() != 0) && tx_ready;
      m_timer = m_timer + 32'd1;
      m_s2    = m_s1;
      m_s1    = sw;
      if (pop) void'(m_q.pop_front());
      if (MemWrite) begin
        if (!DataAdr[12]) begin
          m_ram[idx]   = WriteData;
          m_known[idx] = 1'b1;
        end else begin
          case (DataAdr[4:2])
            3'd0: m_led = WriteData[LED_W-1:0];
            3'd2: m_timer = WriteData;
            3'd3: begin
              if (m_q.size() < FIFO_DEPTH) m_q.push_back(WriteData[7:0]);
              else m_ovf = 1'b1;
            end
            3'd4: if (WriteData[2]) m_ovf = 1'b0;
            default: ;
          endcase
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  fill_a [4];
    logic [7:0]  fill_b [4];
    logic [31:0] a;
    logic        we;
    logic        rdy;
    logic        rst;

    fill_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    fill_b = '{8'hA2, 8'hA3, 8'hA4, 8'h66};

    // Reset held two cycles with garbage on the inputs
    sw_val = 8'h5A;
    drive(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h0000_100C, 32'h0000_0012, 1'b1, 1'b1); tick();
    sw_val = 8'h00;
    drive(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b0);
    chk("rst_timer0", ReadData, 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_txvalid", 32'(tx_valid), 32'h0);
    tick();
    drive(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b0);
    chk("rst_timer1", ReadData, 32'h1);
    tick();
    drive(1'b0, 32'h0000_1010, 32'h0, 1'b0, 1'b0);
    chk("rst_txstat", ReadData, 32'h1);
    tick();

    // RAM write/read, aliasing and same-cycle write invisibility
    drive(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0000_0004, 32'h0, 1'b0, 1'b0);
    chk("ram_rd4", ReadData, 32'hDEAD_BEEF); tick();
    drive(1'b0, 32'h0000_0008, 32'h0, 1'b0, 1'b0);
    chk("ram_rd8", ReadData, 32'h1234_5678); tick();
    drive(1'b0, 32'h0000_0004 + RAM_WORDS * 4, 32'h0, 1'b0, 1'b0);
    chk("ram_alias", ReadData, 32'hDEAD_BEEF); tick();
    drive(1'b1, 32'h0000_0010, 32'h0000_1111, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0000_0010, 32'h0000_2222, 1'b0, 1'b0);
    chk("ram_same_cycle", ReadData, 32'h0000_1111); tick();
    drive(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
    chk("ram_next_cycle", ReadData, 32'h0000_2222); tick();
    drive(1'b1, 32'h0000_000C, 32'hCAFE_F00D, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0000_100C, 32'h0000_00AB, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0000_000C, 32'h0, 1'b0, 1'b0);
    chk("ram_word3_kept", ReadData, 32'hCAFE_F00D);
    chk("txdata_ab", 32'(tx_data), 32'h0000_00AB);
    tick();
    drive(1'b0, 32'h0000_1010, 32'h0, 1'b1, 1'b0); tick();

    // LED register and switch synchronizer
    drive(1'b1, 32'h0000_1000, 32'hFFFF_FFA5, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0);
    chk("led_rd", ReadData, 32'h0000_00A5);
    chk("led_pin", 32'(led), 32'h0000_00A5);
    tick();
    sw_val = 8'h3C;
    drive(1'b0, 32'h0000_1004, 32'h0, 1'b0, 1'b0);
    chk("sw_lat0", ReadData, 32'h0); tick();
    drive(1'b0, 32'h0000_1004, 32'h0, 1'b0, 1'b0);
    chk("sw_lat1", ReadData, 32'h0); tick();
    drive(1'b0, 32'h0000_1004, 32'h0, 1'b0, 1'b0);
    chk("sw_lat2", ReadData, 32'h0000_003C); tick();
    drive(1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0000_1004, 32'h0, 1'b0, 1'b0);
    chk("sw_readonly", ReadData, 32'h0000_003C); tick();

    // Timer load and wrap
    drive(1'b1, 32'h0000_1008, 32'hFFFF_FFFE, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b0);
    chk("timer_v", ReadData, 32'hFFFF_FFFE); tick();
    drive(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b0);
    chk("timer_v1", ReadData, 32'hFFFF_FFFF); tick();
    drive(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b0);
    chk("timer_wrap", ReadData, 32'h0); tick();

    // FIFO fill, overflow, clear and drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_100C, 32'(fill_a[i]), 1'b0, 1'b0); tick();
    end
    drive(1'b0, 32'h0000_1010, 32'h0, 1'b0, 1'b0);
    chk("txstat_full", ReadData, 32'h0000_0402); tick();
    drive(1'b1, 32'h0000_100C, 32'h0000_0055, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0000_1010, 32'h0, 1'b0, 1'b0);
    chk("txstat_ovf", ReadData, 32'h0000_0406); tick();
    drive(1'b1, 32'h0000_1010, 32'h0000_0004, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0000_1010, 32'h0, 1'b0, 1'b0);
    chk("txstat_clr", ReadData, 32'h0000_0402); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0000_1010, 32'h0, 1'b1, 1'b0);
      chk("drain_a_valid", 32'(tx_valid), 32'h1);
      chk("drain_a_data", 32'(tx_data), 32'(fill_a[i]));
      tick();
    end
    drive(1'b0, 32'h0000_1010, 32'h0, 1'b0, 1'b0);
    chk("drain_a_empty", 32'(tx_valid), 32'h0);
    chk("drain_a_stat", ReadData, 32'h0000_0001);
    tick();

    // Push while full with a simultaneous pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_100C, 32'h0000_00A1 + 32'(i), 1'b0, 1'b0); tick();
    end
    drive(1'b1, 32'h0000_100C, 32'h0000_0066, 1'b1, 1'b0);
    chk("pp_head", 32'(tx_data), 32'h0000_00A1); tick();
    drive(1'b0, 32'h0000_1010, 32'h0, 1'b0, 1'b0);
    chk("pp_stat", ReadData, 32'h0000_0402); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0000_1010, 32'h0, 1'b1, 1'b0);
      chk("drain_b_data", 32'(tx_data), 32'(fill_b[i]));
      tick();
    end
    drive(1'b0, 32'h0000_1010, 32'h0, 1'b0, 1'b0);
    chk("drain_b_empty", 32'(tx_valid), 32'h0); tick();

    // Reset with two entries held; push and pop in the reset cycle ignored
    drive(1'b1, 32'h0000_100C, 32'h0000_0077, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0000_100C, 32'h0000_0088, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h0000_100C, 32'h0000_0099, 1'b1, 1'b1); tick();
    drive(1'b0, 32'h0000_1010, 32'h0, 1'b1, 1'b0);
    chk("mid_rst_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_stat", ReadData, 32'h0000_0001);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0000_1010, 32'h0, 1'b1, 1'b0); tick();
    end

    // Randomized traffic across the whole map
    for (int n = 0; n < 600; n++) begin
      we  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 80) == 0);
      sw_val = SW_W'($urandom);
      case ($urandom_range(0, 3))
        0: a = $urandom & ~32'h0000_1000;
        1: a = ($urandom & 32'hFFFF_E003) | 32'h0000_100C;
        default: a = ($urandom & 32'hFFFF_E003) | 32'h0000_1000 |
                     (32'($urandom_range(0, 7)) << 2);
      endcase
      drive(we, a, $urandom, rdy, rst);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
